// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes encoded ops to one-hot ALU function, issues through S1 and captures results in S2.
// Two-entry valid/ready pipeline with tag passthrough and a saturating illegal-op counter.
module alu_issue_stage #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [11:0]      alu_f,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);
  logic             s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
  logic [11:0]      s1_f_q, s1_f_d;
  logic [31:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d, s2_err_q, s2_err_d;
  logic [31:0]      s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             s2_take, s1_move, accept, illegal;
  always_comb begin
    s2_take    = !s2_valid_q | out_ready;
    s1_move    = s1_valid_q & s2_take;
    in_ready   = !s1_valid_q | s2_take;
    accept     = in_valid & in_ready;
    illegal    = in_op >= 4'd12;
    s1_valid_d = accept | (s1_valid_q & !s1_move);
    s1_f_d     = accept ? (illegal ? 12'd0 : 12'd1 << in_op) : s1_f_q;
    s1_err_d   = accept ? illegal : s1_err_q;
    s1_a_d     = accept ? in_a : s1_a_q;
    s1_b_d     = accept ? in_b : s1_b_q;
    s1_tag_d   = accept ? in_tag : s1_tag_q;
    s2_valid_d = s1_move | (s2_valid_q & !out_ready);
    s2_data_d  = s1_move ? (s1_err_q ? 32'd0 : alu_y) : s2_data_q;
    s2_tag_d   = s1_move ? s1_tag_q : s2_tag_q;
    s2_err_d   = s1_move ? s1_err_q : s2_err_q;
    err_cnt_d  = (s2_valid_q & out_ready & s2_err_q & (err_cnt_q != {CNT_W{1'b1}})) ? err_cnt_q + 1'b1 : err_cnt_q;
    alu_f      = s1_valid_q ? s1_f_q : 12'd0;
    alu_a      = s1_a_q;
    alu_b      = s1_b_q;
    out_valid  = s2_valid_q;
    out_data   = s2_data_q;
    out_tag    = s2_tag_q;
    out_err    = s2_err_q;
    err_cnt    = err_cnt_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_f_q     <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_f_q     <= s1_f_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed scoreboard bench for alu_issue_stage, with a behavioural ALU and a CNT_W=2 twin.
module tb_alu_issue_stage;
  logic        clk = 0, rstn = 0;
  logic        in_valid = 0, out_ready = 0;
  logic [3:0]  in_op = 0, in_tag = 0;
  logic [31:0] in_a = 0, in_b = 0;
  logic        in_ready, out_valid, out_err, in_ready2, out_valid2, out_err2;
  logic [11:0] alu_f, alu_f2;
  logic [31:0] alu_a, alu_b, alu_y, out_data, alu_a2, alu_b2, alu_y2, out_data2;
  logic [3:0]  out_tag, out_tag2;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;
  int total = 0, bad = 0;
  logic [36:0] q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [11:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return {31'd0, $signed(a) < $signed(b)};
      12'h008: return {31'd0, a < b};
      12'h010: return a & b;
      12'h020: return a | b;
      12'h040: return ~(a | b);
      12'h080: return a ^ b;
      12'h100: return a << b[4:0];
      12'h200: return a >> b[4:0];
      12'h400: return $signed(a) >>> b[4:0];
      12'h800: return b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] expect_y(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return $signed(a) >>> b[4:0];
      4'd11: return b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_y  = alu(alu_f, alu_a, alu_b);
  assign alu_y2 = alu(alu_f2, alu_a2, alu_b2);

  alu_issue_stage u1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err), .err_cnt(err_cnt)
  );

  alu_issue_stage #(.TAG_W(4), .CNT_W(2)) u2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .alu_f(alu_f2), .alu_a(alu_a2), .alu_b(alu_b2),
    .alu_y(alu_y2), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_tag(out_tag2), .out_err(out_err2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", {27'd0, out_data, out_tag, out_err}, 64'd0);
      else begin
        logic [36:0] e;
        e = q.pop_front();
        chk("out_beat", {27'd0, out_data, out_tag, out_err}, {27'd0, e});
        chk("out_beat_twin", {26'd0, out_valid2, out_data2, out_tag2, out_err2}, {26'd1, e});
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    logic ok;
    ok = 0;
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back({expect_y(op, a, b), tag, op >= 4'd12});
        ok = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("accepted", {63'd0, ok}, 64'd1);
    chk("alu_f", {52'd0, alu_f}, (op < 4'd12) ? (64'd1 << op) : 64'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drained", {32'd0, q.size()}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_outs", {out_data, out_tag, out_err, alu_f, 15'd0}, 64'd0);
    chk("rst_err_cnt", {48'd0, err_cnt}, 64'd0);
    @(posedge clk); #1; rstn = 1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_alu", {alu_a, alu_b}, 64'd0);
    out_ready = 1;
    send(4'd0, 32'd5, 32'd7, 4'd1);
    chk("lat_not_yet", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_data", {32'd0, out_data}, 64'd12);
    send(4'd1, 32'd3, 32'd5, 4'd2);
    send(4'd2, 32'd3, 32'd5, 4'd3);
    send(4'd10, 32'h8000_0000, 32'd4, 4'd7);
    send(4'd6, 32'h0F0F_0000, 32'h0000_00F0, 4'd8);
    drain();
    out_ready = 0;
    send(4'd11, 32'd0, 32'd1, 4'd4);
    send(4'd11, 32'd0, 32'd2, 4'd5);
    in_valid = 1; in_op = 4'd11; in_a = 0; in_b = 32'd3; in_tag = 4'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_hold", {27'd0, out_valid, out_data, out_tag}, {27'd1, 32'd1, 4'd4});
    end
    @(posedge clk); #1;
    out_ready = 1;
    send(4'd11, 32'd0, 32'd3, 4'd6);
    drain();
    send(4'd13, 32'd1, 32'd1, 4'd5);
    drain();
    chk("err_cnt_1", {48'd0, err_cnt}, 64'd1);
    for (int i = 0; i < 4; i++) send(4'(12 + i), 32'd9, 32'd9, 4'(i));
    drain();
    @(posedge clk); #1;
    chk("err_cnt_5", {48'd0, err_cnt}, 64'd5);
    chk("err_cnt_sat", {62'd0, err_cnt2}, 64'd3);
    out_ready = 0;
    send(4'd11, 32'd0, 32'd7, 4'd1);
    send(4'd11, 32'd0, 32'd8, 4'd2);
    #2; rstn = 0; #1;
    chk("amid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("amid_err_cnt", {46'd0, err_cnt, err_cnt2}, 64'd0);
    chk("amid_alu_f", {52'd0, alu_f}, 64'd0);
    q.delete();
    @(posedge clk); #1; rstn = 1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) send(4'(3 + i), 32'hFFFF_0000 + i, 32'd5 + i, 4'(9 + i));
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
